// File: rtl/cmp_arbiter.sv
// cmp_arbiter: two-requester arbiter in front of a shared signed comparator.
// A winning requester's operands are captured, compared two cycles later and
// the result is held in gt/eq/lt until the next compare completes.
// Optional feature: define CMP_ARB_RR_EN for round-robin tie-break; without
// it requester 0 always wins a tie and no last-grant pointer exists.
module cmp_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic [1:0]       gnt,
    output logic             busy,
    output logic             done0,
    output logic             done1,
    output logic             gt,
    output logic             eq,
    output logic             lt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CAP  = 2'd1,
        CMP  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic [1:0]               gnt_q, gnt_d;
    logic                     done0_q, done0_d;
    logic                     done1_q, done1_d;
    logic                     gt_q, gt_d;
    logic                     eq_q, eq_d;
    logic                     lt_q, lt_d;
    logic signed [WIDTH-1:0]  opa_q, opa_d;
    logic signed [WIDTH-1:0]  opb_q, opb_d;
    logic                     win1;

`ifdef CMP_ARB_RR_EN
    // Last-grant pointer: 1 means requester 1 was granted most recently.
    logic                     last_q, last_d;

    // Tie goes to whichever requester was not granted last.
    always_comb begin
        win1 = req1 & (~req0 | ~last_q);
    end
`else
    // Fixed priority: requester 1 only wins when requester 0 is idle.
    always_comb begin
        win1 = req1 & ~req0;
    end
`endif

    // Next-state, grant, operand capture and result evaluation.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        done0_d = 1'b0;
        done1_d = 1'b0;
        gt_d    = gt_q;
        eq_d    = eq_q;
        lt_d    = lt_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
`ifdef CMP_ARB_RR_EN
        last_d  = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    state_d = CAP;
                    gnt_d   = win1 ? 2'b10 : 2'b01;
                    opa_d   = win1 ? a1 : a0;
                    opb_d   = win1 ? b1 : b0;
`ifdef CMP_ARB_RR_EN
                    last_d  = win1;
`endif
                end
            end
            CAP: begin
                state_d = CMP;
            end
            CMP: begin
                // Result and completion pulse both appear on entry to DONE.
                state_d = DONE;
                gt_d    = (opa_q >  opb_q);
                eq_d    = (opa_q == opb_q);
                lt_d    = (opa_q <  opb_q);
                done0_d = gnt_q[0];
                done1_d = gnt_q[1];
            end
            DONE: begin
                state_d = IDLE;
                gnt_d   = 2'b00;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 2'b00;
            end
        endcase
    end

    // State and output registers; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= 2'b00;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            gt_q    <= 1'b0;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
            opa_q   <= '0;
            opb_q   <= '0;
`ifdef CMP_ARB_RR_EN
            last_q  <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
            gt_q    <= gt_d;
            eq_q    <= eq_d;
            lt_q    <= lt_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
`ifdef CMP_ARB_RR_EN
            last_q  <= last_d;
`endif
        end
    end

    assign busy  = (state_q != IDLE);
    assign gnt   = gnt_q;
    assign done0 = done0_q;
    assign done1 = done1_q;
    assign gt    = gt_q;
    assign eq    = eq_q;
    assign lt    = lt_q;

endmodule

// File: tb/tb_cmp_arbiter.sv
// Testbench for cmp_arbiter: vector table of compare transactions with a
// scoreboard queue, plus hand sequences for hold, reset abort and held ties.
module tb_cmp_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1;
    logic [3:0] a0, b0, a1, b1;
    logic [1:0] gnt;
    logic       busy, done0, done1, gt, eq, lt;

    cmp_arbiter #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .req0  (req0),
        .a0    (a0),
        .b0    (b0),
        .req1  (req1),
        .a1    (a1),
        .b1    (b1),
        .gnt   (gnt),
        .busy  (busy),
        .done0 (done0),
        .done1 (done1),
        .gt    (gt),
        .eq    (eq),
        .lt    (lt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       r0;
        logic       r1;
        logic [3:0] a0;
        logic [3:0] b0;
        logic [3:0] a1;
        logic [3:0] b1;
        logic [1:0] gnt;    // expected grant / done vector
        logic [2:0] flags;  // expected {gt,eq,lt}
    } vec_t;

    typedef struct {
        logic [1:0] gnt;
        logic [2:0] flags;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Caller is at a falling edge with the DUT in IDLE. Returns at the
    // falling edge of the IDLE cycle that follows the operation.
    task automatic issue(input vec_t v, input bit hold);
        exp_t e;
        exp_t got_e;
        int   waited;
        bit   got;
        req0 = v.r0; req1 = v.r1;
        a0 = v.a0; b0 = v.b0; a1 = v.a1; b1 = v.b1;
        e.gnt = v.gnt; e.flags = v.flags;
        sbq.push_back(e);
        @(posedge clk);
        @(negedge clk);                      // CAP
        chk("gnt_cap", {6'd0, gnt}, {6'd0, v.gnt});
        chk("busy_cap", {7'd0, busy}, 8'd1);
        if (!hold) begin
            req0 = 1'b0; req1 = 1'b0;
        end
        @(negedge clk);                      // CMP: scramble operands after capture
        chk("gnt_cmp", {6'd0, gnt}, {6'd0, v.gnt});
        chk("done_early", {6'd0, done1, done0}, 8'd0);
        a0 = 4'b1000; b0 = 4'b0111; a1 = 4'b1000; b1 = 4'b0111;
        got = 1'b0;
        waited = 0;
        for (int i = 0; i < 6 && !got; i++) begin
            @(negedge clk);
            waited++;
            if (done0 || done1) got = 1'b1;
        end
        if (!got) begin
            errors++;
            checks++;
            $display("FAIL done_timeout actual=none expected=%0h", v.gnt);
        end else begin
            got_e = sbq.pop_front();
            chk("done_latency", waited[7:0], 8'd1);
            chk("done_vec", {6'd0, done1, done0}, {6'd0, got_e.gnt});
            chk("gnt_done", {6'd0, gnt}, {6'd0, got_e.gnt});
            chk("flags", {5'd0, gt, eq, lt}, {5'd0, got_e.flags});
        end
        @(negedge clk);                      // IDLE
        chk("idle_done", {6'd0, done1, done0}, 8'd0);
        chk("idle_busy", {7'd0, busy}, 8'd0);
        chk("idle_gnt", {6'd0, gnt}, 8'd0);
    endtask

    vec_t vt[9];
    vec_t tv;

    initial begin
        vt[0] = '{1'b1, 1'b0, 4'b0010, 4'b0001, 4'b0000, 4'b0000, 2'b01, 3'b100};
        vt[1] = '{1'b0, 1'b1, 4'b0000, 4'b0000, 4'b1110, 4'b1111, 2'b10, 3'b001};
        vt[2] = '{1'b0, 1'b1, 4'b0000, 4'b0000, 4'b1101, 4'b1101, 2'b10, 3'b010};
        vt[3] = '{1'b1, 1'b0, 4'b0001, 4'b1111, 4'b0000, 4'b0000, 2'b01, 3'b100};
        vt[4] = '{1'b1, 1'b0, 4'b1111, 4'b0001, 4'b0000, 4'b0000, 2'b01, 3'b001};
`ifdef CMP_ARB_RR_EN
        vt[5] = '{1'b1, 1'b1, 4'b0111, 4'b1000, 4'b1000, 4'b0111, 2'b10, 3'b001};
`else
        vt[5] = '{1'b1, 1'b1, 4'b0111, 4'b1000, 4'b1000, 4'b0111, 2'b01, 3'b100};
`endif
        vt[6] = '{1'b1, 1'b1, 4'b0111, 4'b1000, 4'b1000, 4'b0111, 2'b01, 3'b100};
        vt[7] = '{1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0111, 4'b0111, 2'b10, 3'b010};
        vt[8] = '{1'b1, 1'b1, 4'b1000, 4'b1000, 4'b0000, 4'b1111, 2'b01, 3'b010};

        // Reset held with a pending request: nothing may start.
        rst = 1'b1; req0 = 1'b1; req1 = 1'b0;
        a0 = 4'b0011; b0 = 4'b0001; a1 = '0; b1 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {7'd0, busy}, 8'd0);
        chk("rst_gnt", {6'd0, gnt}, 8'd0);
        chk("rst_done", {6'd0, done1, done0}, 8'd0);
        chk("rst_flags", {5'd0, gt, eq, lt}, 8'd0);
        rst = 1'b0; req0 = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 9; i++) issue(vt[i], 1'b0);

        // Result holds while idle, even with operands toggling.
        for (int i = 0; i < 3; i++) begin
            a0 = 4'(i); b0 = 4'(i + 5);
            @(negedge clk);
            chk("hold_flags", {5'd0, gt, eq, lt}, 8'b010);
            chk("hold_busy", {7'd0, busy}, 8'd0);
        end

        // Reset for one cycle during CMP aborts without a done pulse.
        req0 = 1'b1; a0 = 4'b0101; b0 = 4'b0001;
        @(posedge clk);
        @(negedge clk);                      // CAP
        req0 = 1'b0;
        @(negedge clk);                      // CMP
        chk("abort_pre_busy", {7'd0, busy}, 8'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", {7'd0, busy}, 8'd0);
        chk("abort_gnt", {6'd0, gnt}, 8'd0);
        chk("abort_done", {6'd0, done1, done0}, 8'd0);
        chk("abort_flags", {5'd0, gt, eq, lt}, 8'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_quiet", {5'd0, busy, done1, done0}, 8'd0);
        end

        // Both requests held continuously across successive operations.
        for (int i = 0; i < 4; i++) begin
            tv = '{1'b1, 1'b1, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 2'b01, 3'b100};
`ifdef CMP_ARB_RR_EN
            if (i % 2 == 1) begin
                tv.gnt = 2'b10;
                tv.flags = 3'b001;
            end
`endif
            issue(tv, 1'b1);
        end
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);

        chk("sb_empty", 8'(sbq.size()), 8'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
